// File: rtl/tmp101_poll_scheduler.sv
// Round-robin poller that time-shares one I2C temperature-read unit across
// up to eight TMP101 sensors and keeps the latest reading of each one.
module tmp101_poll_scheduler #(
    parameter logic [19:0] TimeoutCycles = 20'd750000,
    parameter logic [19:0] GapCycles     = 20'd75000
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] SensorMask,
    input  logic       Done,
    input  logic [7:0] ReceivedData,
    input  logic [2:0] ReadSelect,
    output logic       Start,
    output logic [7:0] Address,
    output logic [2:0] CurrentSensor,
    output logic       Busy,
    output logic       SampleValid,
    output logic [2:0] SampleSensor,
    output logic [7:0] SampleData,
    output logic [7:0] ReadTemp,
    output logic [7:0] ValidFlags,
    output logic [7:0] TimeoutFlags
);

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_SENS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_prev_q;
    logic                start_q;
    logic                busy_q;
    logic                sample_valid_q;
    logic [IDX_W-1:0]    sample_sensor_q, sample_sensor_d;
    logic [DATA_W-1:0]   sample_data_q, sample_data_d;
    logic [N_SENS-1:0]   valid_q, valid_d;
    logic [N_SENS-1:0]   timeout_q, timeout_d;
    logic [DATA_W-1:0]   temp_q [N_SENS];
    logic                temp_we;
    logic                done_evt;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;

    // Round-robin search for the next masked sensor after the last one served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = '0;
        for (int k = 1; k <= int'(N_SENS); k++) begin
            cand = IDX_W'(ptr_q + IDX_W'(k));
            if (!sel_found && SensorMask[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state and datapath updates for the polling sequence.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cur_d           = cur_q;
        cnt_d           = cnt_q;
        valid_d         = valid_q;
        timeout_d       = timeout_q;
        sample_sensor_d = sample_sensor_q;
        sample_data_d   = sample_data_q;
        temp_we         = 1'b0;
        done_evt        = Done && !done_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (Enable && (SensorMask != '0)) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!sel_found) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d   = sel_idx;
                    cur_d   = sel_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done event on the last allowed cycle still counts as a reply.
                if (done_evt) begin
                    sample_sensor_d = cur_q;
                    sample_data_d   = ReceivedData;
                    state_d         = ST_STORE;
                end else if (cnt_q == (TimeoutCycles - 20'd1)) begin
                    timeout_d[cur_q] = 1'b1;
                    valid_d[cur_q]   = 1'b0;
                    cnt_d            = '0;
                    state_d          = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_STORE: begin
                temp_we          = 1'b1;
                valid_d[cur_q]   = 1'b1;
                timeout_d[cur_q] = 1'b0;
                cnt_d            = '0;
                state_d          = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == (GapCycles - 20'd1)) begin
                    cnt_d   = '0;
                    state_d = (Enable && (SensorMask != '0)) ? ST_SELECT : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, control and registered output flops.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q         <= ST_IDLE;
            ptr_q           <= 3'd7;
            cur_q           <= '0;
            cnt_q           <= '0;
            done_prev_q     <= 1'b0;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            sample_valid_q  <= 1'b0;
            sample_sensor_q <= '0;
            sample_data_q   <= '0;
            valid_q         <= '0;
            timeout_q       <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cur_q           <= cur_d;
            cnt_q           <= cnt_d;
            done_prev_q     <= Done;
            start_q         <= (state_d == ST_ISSUE);
            busy_q          <= (state_d != ST_IDLE);
            sample_valid_q  <= (state_d == ST_STORE);
            sample_sensor_q <= sample_sensor_d;
            sample_data_q   <= sample_data_d;
            valid_q         <= valid_d;
            timeout_q       <= timeout_d;
        end
    end

    // Per-sensor temperature register file, written once per successful read.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(N_SENS); i++) begin
                temp_q[i] <= '0;
            end
        end else if (temp_we) begin
            temp_q[cur_q] <= sample_data_q;
        end
    end

    assign Start         = start_q;
    assign Address       = {4'b1001, cur_q, 1'b1};
    assign CurrentSensor = cur_q;
    assign Busy          = busy_q;
    assign SampleValid   = sample_valid_q;
    assign SampleSensor  = sample_sensor_q;
    assign SampleData    = sample_data_q;
    assign ReadTemp      = temp_q[ReadSelect];
    assign ValidFlags    = valid_q;
    assign TimeoutFlags  = timeout_q;

endmodule

// File: tb/tb_tmp101_poll_scheduler.sv
// Directed bench for tmp101_poll_scheduler with a simple I2C read-unit model.
module tb_tmp101_poll_scheduler;

    logic       clk;
    logic       Reset;
    logic       Enable;
    logic [7:0] SensorMask;
    logic       Done;
    logic [7:0] ReceivedData;
    logic [2:0] ReadSelect;
    logic       Start;
    logic [7:0] Address;
    logic [2:0] CurrentSensor;
    logic       Busy;
    logic       SampleValid;
    logic [2:0] SampleSensor;
    logic [7:0] SampleData;
    logic [7:0] ReadTemp;
    logic [7:0] ValidFlags;
    logic [7:0] TimeoutFlags;

    int n_checks = 0;
    int n_err    = 0;

    // I2C model configuration
    logic [7:0] resp_data [8];
    logic [7:0] resp_en;
    int         delay;

    tmp101_poll_scheduler #(
        .TimeoutCycles(20'd50),
        .GapCycles    (20'd4)
    ) dut (
        .clock        (clk),
        .Reset        (Reset),
        .Enable       (Enable),
        .SensorMask   (SensorMask),
        .Done         (Done),
        .ReceivedData (ReceivedData),
        .ReadSelect   (ReadSelect),
        .Start        (Start),
        .Address      (Address),
        .CurrentSensor(CurrentSensor),
        .Busy         (Busy),
        .SampleValid  (SampleValid),
        .SampleSensor (SampleSensor),
        .SampleData   (SampleData),
        .ReadTemp     (ReadTemp),
        .ValidFlags   (ValidFlags),
        .TimeoutFlags (TimeoutFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C read unit: one-cycle Done 'delay' cycles after Start, if the addressed sensor answers.
    initial begin : i2c_model
        int         mcnt;
        logic       pend;
        logic [2:0] maddr;
        Done         = 1'b0;
        ReceivedData = 8'h00;
        mcnt         = 0;
        pend         = 1'b0;
        maddr        = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            Done = 1'b0;
            if (Reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        pend = 1'b0;
                        if (resp_en[maddr]) begin
                            Done         = 1'b1;
                            ReceivedData = resp_data[maddr];
                        end
                    end
                end
                if (Start && !pend) begin
                    pend  = 1'b1;
                    mcnt  = delay;
                    maddr = Address[3:1];
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for Start, then check it arrived and with the right address.
    task automatic expect_start(input string tag, input logic [7:0] exp_addr,
                                input int max_cyc, output int n);
        n = 0;
        while (Start !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " start"}, 32'(Start), 32'd1);
        check_eq({tag, " addr"}, 32'(Address), 32'(exp_addr));
    endtask

    // Wait (bounded) for SampleValid, then check sensor index and data.
    task automatic expect_sample(input string tag, input logic [2:0] exp_s,
                                 input logic [7:0] exp_d, input int max_cyc, output int n);
        n = 0;
        while (SampleValid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " valid"}, 32'(SampleValid), 32'd1);
        check_eq({tag, " sensor"}, 32'(SampleSensor), 32'(exp_s));
        check_eq({tag, " data"}, 32'(SampleData), 32'(exp_d));
    endtask

    initial begin : main
        int n;
        int cnt;

        Reset      = 1'b1;
        Enable     = 1'b0;
        SensorMask = 8'h00;
        ReadSelect = 3'd0;
        delay      = 10;
        resp_en    = 8'h7F;
        for (int i = 0; i < 8; i++) resp_data[i] = 8'(8'h10 + i);
        resp_data[0] = 8'h19;
        resp_data[2] = 8'h1E;
        resp_data[3] = 8'h20;

        repeat (3) @(negedge clk);
        check_eq("rst start", 32'(Start), 32'd0);
        check_eq("rst busy", 32'(Busy), 32'd0);
        check_eq("rst svalid", 32'(SampleValid), 32'd0);
        check_eq("rst cursensor", 32'(CurrentSensor), 32'd0);
        check_eq("rst vflags", 32'(ValidFlags), 32'd0);
        check_eq("rst tflags", 32'(TimeoutFlags), 32'd0);
        check_eq("rst readtemp", 32'(ReadTemp), 32'd0);

        // 1: two sensors polled in round-robin order
        Reset = 1'b0;
        @(negedge clk);
        SensorMask = 8'h05;
        Enable     = 1'b1;
        expect_start("t1 s0", 8'h91, 20, n);
        check_eq("t1 en->start lat", 32'(n), 32'd2);
        check_eq("t1 busy", 32'(Busy), 32'd1);
        expect_sample("t1 s0", 3'd0, 8'h19, 30, n);
        check_eq("t1 start->sample lat", 32'(n), 32'd11);
        expect_start("t1 s2", 8'h95, 20, n);
        check_eq("t1 sample->start lat", 32'(n), 32'd6);
        expect_sample("t1 s2", 3'd2, 8'h1E, 30, n);
        expect_start("t1 s0 again", 8'h91, 20, n);
        ReadSelect = 3'd2;
        #1;
        check_eq("t1 vflags", 32'(ValidFlags), 32'h05);
        check_eq("t1 readtemp2", 32'(ReadTemp), 32'h1E);
        expect_sample("t1 s0 again", 3'd0, 8'h19, 30, n);

        // 2: absent sensor 7 times out and is retried
        SensorMask = 8'h80;
        expect_start("t2 s7", 8'h9F, 20, n);
        check_eq("t2 sample->start lat", 32'(n), 32'd6);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (SampleValid) cnt++;
        end
        check_eq("t2 tflags before", 32'(TimeoutFlags), 32'h00);
        @(negedge clk);
        check_eq("t2 tflags after", 32'(TimeoutFlags), 32'h80);
        check_eq("t2 no sample", 32'(cnt), 32'd0);
        check_eq("t2 vflags kept", 32'(ValidFlags), 32'h05);
        expect_start("t2 retry", 8'h9F, 20, n);
        check_eq("t2 retry lat", 32'(n), 32'd5);

        // 3: sensor 3 answers once, then stops answering
        SensorMask = 8'h08;
        @(negedge clk);
        expect_start("t3 s3", 8'h97, 80, n);
        expect_sample("t3 s3", 3'd3, 8'h20, 30, n);
        @(negedge clk);
        check_eq("t3 vflags", 32'(ValidFlags), 32'h0D);
        check_eq("t3 tflags", 32'(TimeoutFlags), 32'h80);
        resp_en[3] = 1'b0;
        expect_start("t3 s3 miss", 8'h97, 20, n);
        repeat (51) @(negedge clk);
        ReadSelect = 3'd3;
        #1;
        check_eq("t3 vflag3 cleared", 32'(ValidFlags[3]), 32'd0);
        check_eq("t3 tflags", 32'(TimeoutFlags), 32'h88);
        check_eq("t3 readtemp3 kept", 32'(ReadTemp), 32'h20);

        // 5: Done on the last WAIT cycle is still a valid reply
        resp_en[3]   = 1'b1;
        resp_data[3] = 8'h21;
        delay        = 50;
        expect_start("t5 s3", 8'h97, 20, n);
        expect_sample("t5 s3", 3'd3, 8'h21, 60, n);
        check_eq("t5 lat", 32'(n), 32'd51);
        @(negedge clk);
        check_eq("t5 tflags", 32'(TimeoutFlags), 32'h80);
        check_eq("t5 vflags", 32'(ValidFlags), 32'h0D);

        // 4: Enable dropped mid-transaction
        delay        = 10;
        resp_data[3] = 8'h22;
        expect_start("t4 s3", 8'h97, 20, n);
        @(negedge clk);
        Enable = 1'b0;
        expect_sample("t4 s3", 3'd3, 8'h22, 20, n);
        repeat (4) @(negedge clk);
        check_eq("t4 busy in gap", 32'(Busy), 32'd1);
        @(negedge clk);
        check_eq("t4 busy idle", 32'(Busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (Start) cnt++;
        end
        check_eq("t4 no start", 32'(cnt), 32'd0);
        check_eq("t4 readtemp3", 32'(ReadTemp), 32'h22);

        // 6: asynchronous reset during WAIT
        SensorMask = 8'h0C;
        Enable     = 1'b1;
        expect_start("t6 s2 wrap", 8'h95, 20, n);
        check_eq("t6 lat", 32'(n), 32'd2);
        repeat (5) @(negedge clk);
        Reset = 1'b1;
        #1;
        check_eq("t6 rst busy", 32'(Busy), 32'd0);
        check_eq("t6 rst cursensor", 32'(CurrentSensor), 32'd0);
        check_eq("t6 rst vflags", 32'(ValidFlags), 32'd0);
        check_eq("t6 rst tflags", 32'(TimeoutFlags), 32'd0);
        check_eq("t6 rst readtemp", 32'(ReadTemp), 32'd0);
        check_eq("t6 rst sdata", 32'(SampleData), 32'd0);
        @(negedge clk);
        Reset      = 1'b0;
        SensorMask = 8'h05;
        expect_start("t6 after rst", 8'h91, 20, n);
        check_eq("t6 after rst lat", 32'(n), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
